sine_filt: RTL and testbench
============================

Name: sine_filt

Overview:
- 21-tap symmetric linear-phase low-pass FIR filter for 18-bit signed 1s17 samples (1 sign bit, 17 fractional bits).
- Sits in the sine-generation/DSP datapath.
- Takes one input sample per clock and produces one filtered sample per clock.
- Fully pipelined with fixed latency; coefficients are constants, with no run-time programming.

Parameters:
- NTAPS, 21, number of taps; fixed odd value, symmetric coefficient set.
- ACC_W, 40, accumulator width in bits; must be ≥ 38.

Ports:
- clk  input  1  single clock; all logic rising-edge.
- reset  input  1  synchronous, active-low reset (0 = reset asserted).
- x_in  input  18  signed 1s17 input sample, sampled every rising edge.
- y  output  18  signed 1s17 filtered output, registered.

Behaviour:
- Reset is synchronous and active-low. Any rising edge with reset==0 clears the following to 0:
  - delay line tap[0..20]
  - all pre-add, product and sum registers
  - y
- Delay line:
  - Each edge out of reset: tap[0] <= x_in; tap[k] <= tap[k-1].
- Coefficients (1s17 integers):
  - h[k] = 1024*(k+1) for k = 0..10.
  - h[20-k] = h[k].
  - Center h[10] = 11264.
  - Sum of h = 123904 (< 2^17), so no internal overflow is possible for any input.
- Stage 2, pre-add:
  - p[k] = tap[k] + tap[20-k] for k = 0..9, 19-bit signed.
  - p[10] = tap[10], sign-extended.
  - All registered.
- Stage 3, multiply:
  - m[k] = p[k] * h[k], signed, 37 bits, registered.
  - Eleven multipliers.
- Stage 4, sum:
  - s = sum of m[0..10], sign-extended to ACC_W, registered.
- Stage 5, output:
  - y <= s[34:17], truncation toward −inf (unless ROUND feature enabled).
- Latency:
  - A sample present on x_in at edge n first contributes to y at edge n+4.
  - y(n+4) = Σ h[k]·x(n−k) >> 17.
- Throughput: 1 sample/clock; no handshake, no stall.
- Reset mid-stream: pipeline flushes to zero.
  - After release, y stays 0 until the first post-reset sample propagates (4 edges).
  - Old samples never reappear.
- x_in = −131072 (most negative) is legal. Pre-add of two −131072 values is −262144, which fits in 19 bits.

Optional Feature:
- Macro SINE_FILT_ROUND_EN.
- Defined: stage 5 computes y <= (s + 2^16)[34:17], i.e. round-half-up.
- Undefined: plain truncation as above.
- Latency is identical in both cases.

Test Plan:
- Reset: hold reset=0 for 21 clocks with random x_in -> y==0 on every cycle, and for 4 edges after release with x_in=0.
- Impulse: single x_in=65536 then zeros -> starting 4 edges later, y = 512, 1024, …, 5632 (center), …, 1024, 512, then 0.
  - 21 nonzero samples; both build variants give the same values.
- DC gain: constant x_in=65536 -> after 24 edges y settles to 61952.
- Worst-case positive: constant x_in=131071 -> y=123903 in both variants.
  - Constant x_in=−131072 -> y=−123904.
  - No wrap in either case.
- Alternating ±131071 at Nyquist: y settles to a small bounded value.
  - Must match the bit-exact golden model (Σh·x >> 17) for every sample.
- Mid-stream reset: drive a sine, assert reset=0 for 1 edge -> y=0 on the next edge.
  - Post-release outputs match a model started from zero state.

Source files
------------

// File: rtl/sine_filt.sv
// 21-tap symmetric low-pass FIR for 1s17 samples: delay line, pre-add, multiply, sum, output (latency 4).
// Define SINE_FILT_ROUND_EN to round half-up at the output instead of truncating.
module sine_filt #(
    parameter int NTAPS = 21,
    parameter int ACC_W = 40
) (
    input  logic               clk,
    input  logic               reset,
    input  logic signed [17:0] x_in,
    output logic signed [17:0] y
);

    localparam int NHALF = (NTAPS + 1) / 2;
    localparam int CTR   = NTAPS / 2;
    localparam logic signed [ACC_W-1:0] RND_BIAS = ACC_W'(18'sd65536);

    // Coefficient ramp 1024*(k+1) up to the center tap; mirrored half reuses it via the pre-add.
    function automatic logic signed [17:0] coef(input int k);
        return 18'(32'sd1024 * (k + 32'sd1));
    endfunction

    logic signed [17:0]      tap_r  [NTAPS];
    logic signed [18:0]      pre_r  [NHALF];
    logic signed [36:0]      prod_r [NHALF];
    logic signed [ACC_W-1:0] sum_r;
    logic signed [ACC_W-1:0] sum_s;
    logic signed [ACC_W-1:0] out_s;
    logic                    unused_s;

    // Sample delay line.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NTAPS; i++) tap_r[i] <= '0;
        end else begin
            tap_r[0] <= x_in;
            for (int i = 1; i < NTAPS; i++) tap_r[i] <= tap_r[i-1];
        end
    end

    // Fold symmetric taps; the 19-bit sum holds two most-negative samples without wrap.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int k = 0; k < NHALF; k++) pre_r[k] <= '0;
        end else begin
            for (int k = 0; k < CTR; k++)
                pre_r[k] <= {tap_r[k][17], tap_r[k]} + {tap_r[NTAPS-1-k][17], tap_r[NTAPS-1-k]};
            pre_r[CTR] <= {tap_r[CTR][17], tap_r[CTR]};
        end
    end

    // Constant-coefficient multipliers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int k = 0; k < NHALF; k++) prod_r[k] <= '0;
        end else begin
            for (int k = 0; k < NHALF; k++) prod_r[k] <= 37'(pre_r[k]) * 37'(coef(k));
        end
    end

    // Adder tree over the sign-extended products.
    always_comb begin
        sum_s = '0;
        for (int k = 0; k < NHALF; k++) sum_s = sum_s + ACC_W'(prod_r[k]);
    end

    // Accumulator register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            sum_r <= '0;
        end else begin
            sum_r <= sum_s;
        end
    end

    // Output quantisation: coefficient sum is below 2^17, so bits above 34 are pure sign.
    always_comb begin
`ifdef SINE_FILT_ROUND_EN
        out_s = sum_r + RND_BIAS;
`else
        out_s = sum_r;
`endif
    end

    assign unused_s = ^{out_s[ACC_W-1:35], out_s[16:0], RND_BIAS};

    // Registered output sample.
    always_ff @(posedge clk) begin
        if (!reset) begin
            y <= '0;
        end else begin
            y <= out_s[34:17];
        end
    end

endmodule

// File: tb/tb_sine_filt.sv
// Directed bench for sine_filt: reset, impulse, DC, extremes, Nyquist and mid-stream reset.
module tb_sine_filt;

    logic               clk = 1'b0;
    logic               reset;
    logic signed [17:0] x_in;
    logic signed [17:0] y;

    int     n_err = 0;
    int     n_chk = 0;
    longint hist [21];
    longint e1 = 0, e2 = 0, e3 = 0, ey = 0;
    int     sine_tab [16];

    sine_filt dut (.clk(clk), .reset(reset), .x_in(x_in), .y(y));

    always #5 clk = ~clk;

    function automatic longint hk(input int k);
        return (k <= 10) ? longint'(1024 * (k + 1)) : longint'(1024 * (21 - k));
    endfunction

    // Direct-form reference: sum of h[k]*x(n-k), arithmetic shift by 17.
    function automatic longint golden();
        longint acc = 0;
        for (int k = 0; k < 21; k++) acc += hk(k) * hist[k];
`ifdef SINE_FILT_ROUND_EN
        acc += 65536;
`endif
        return acc >>> 17;
    endfunction

    task automatic tick(input int x, input logic rst);
        x_in  = 18'(x);
        reset = rst;
        @(posedge clk);
        if (!rst) begin
            for (int k = 0; k < 21; k++) hist[k] = 0;
            e1 = 0; e2 = 0; e3 = 0; ey = 0;
        end else begin
            ey = e3; e3 = e2; e2 = e1; e1 = golden();
            for (int k = 20; k > 0; k--) hist[k] = hist[k-1];
            hist[0] = longint'(x_in);
        end
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input longint expv);
        n_chk++;
        assert (longint'(y) === expv) else begin
            n_err++;
            $error("FAIL %s y=%0d expected=%0d", tag, y, expv);
        end
    endtask

    initial begin
        int j;
        longint iexp;
        sine_tab = '{0, 50159, 92681, 121094, 131071, 121094, 92681, 50159,
                     0, -50159, -92681, -121094, -131071, -121094, -92681, -50159};
        for (int k = 0; k < 21; k++) hist[k] = 0;
        reset = 1'b0;
        x_in  = '0;

        for (int t = 0; t < 21; t++) begin
            tick(int'($urandom_range(0, 262143)) - 131072, 1'b0);
            chk("rst_hold", 0);
        end
        for (int t = 0; t < 4; t++) begin
            tick(0, 1'b1);
            chk("rst_release", 0);
        end

        tick(65536, 1'b1);
        chk("impulse_lat", 0);
        for (int t = 1; t < 30; t++) begin
            tick(0, 1'b1);
            j = t - 4;
            if (j >= 0 && j <= 20) iexp = 512 * (((j <= 10) ? j : 20 - j) + 1);
            else                   iexp = 0;
            chk("impulse", iexp);
        end

        for (int t = 0; t < 30; t++) begin
            tick(65536, 1'b1);
            chk("dc_model", ey);
            if (t >= 24) chk("dc_gain", 61952);
        end
        for (int t = 0; t < 30; t++) begin
            tick(131071, 1'b1);
            if (t >= 24) chk("max_pos", 123903);
        end
        for (int t = 0; t < 30; t++) begin
            tick(-131072, 1'b1);
            chk("max_neg_model", ey);
            if (t >= 24) chk("max_neg", -123904);
        end

        for (int t = 0; t < 40; t++) begin
            tick((t % 2 == 1) ? -131071 : 131071, 1'b1);
            chk("nyquist", ey);
            if (t >= 24) begin
                n_chk++;
                assert (y <= 18'sd1024 && y >= -18'sd1024) else begin
                    n_err++;
                    $error("FAIL nyquist_bound y=%0d expected=|y|<=1024", y);
                end
            end
        end

        for (int t = 0; t < 30; t++) begin
            tick(sine_tab[t % 16], 1'b1);
            chk("sine", ey);
        end
        tick(sine_tab[14], 1'b0);
        chk("midstream_rst", 0);
        for (int t = 0; t < 30; t++) begin
            tick(sine_tab[(t + 3) % 16], 1'b1);
            if (t < 4) chk("post_rst_zero", 0);
            chk("post_rst_model", ey);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
